aes_key_expand: RTL and testbench



---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_sbox.sv | 28 ++
 rtl/aes_key_expand.sv | 109 ++++++++++
 tb/tb_aes_key_expand.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and the GF(2^8) doubling helper.
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int AES_KW = 128;

   localparam logic [1:0] KE_IDLE   = 2'd0;
   localparam logic [1:0] KE_EXPAND = 2'd1;
   localparam logic [1:0] KE_READY  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = KE_IDLE,
      S_EXPAND = KE_EXPAND,
      S_READY  = KE_READY
   } ke_state_t;

   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] XTIME_POLY = 8'h1b;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: purely combinational byte substitution from a constant table.
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry bank,
// then serves the entry chosen by round_index to the round datapath.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NR = AES_NR,
   parameter int KW = AES_KW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_load,
   input  logic [KW-1:0] key_in,
   input  logic [3:0]    round_index,
   output logic [KW-1:0] round_key,
   output logic          key_ready,
   output logic          busy
);

   localparam logic [3:0] LAST = 4'(NR);

   ke_state_t     state;
   logic [3:0]    i;
   logic [7:0]    rcon;
   logic [KW-1:0] rk [0:NR];

   logic [KW-1:0] prev_key;
   logic [KW-1:0] next_key;
   logic [31:0]   w0, w1, w2, w3, w4, w5, w6, w7;
   logic [31:0]   rot_w3, sub_w3, temp;

   always_comb begin
      prev_key = '0;
      if (i != 4'd0 && i <= LAST) prev_key = rk[i - 4'd1];
   end

   assign {w0, w1, w2, w3} = prev_key;
   assign rot_w3 = {w3[23:0], w3[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .din  (rot_w3[8*b +: 8]),
         .dout (sub_w3[8*b +: 8])
      );
   end

   assign temp     = sub_w3 ^ {rcon, 24'h0};
   assign w4       = w0 ^ temp;
   assign w5       = w1 ^ w4;
   assign w6       = w2 ^ w5;
   assign w7       = w3 ^ w6;
   assign next_key = {w4, w5, w6, w7};

   // Out-of-range selects read as zero rather than aliasing a bank entry.
   always_comb begin
      round_key = '0;
      if (round_index <= LAST) round_key = rk[round_index];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         i         <= 4'd0;
         rcon      <= RCON_INIT;
         key_ready <= 1'b0;
         busy      <= 1'b0;
         for (int k = 0; k <= NR; k++) rk[k] <= '0;
      end else begin
         case (state)
            S_IDLE, S_READY: begin
               if (key_load) begin
                  rk[0]     <= key_in;
                  i         <= 4'd1;
                  rcon      <= RCON_INIT;
                  state     <= S_EXPAND;
                  busy      <= 1'b1;
                  key_ready <= 1'b0;
               end else begin
                  busy      <= 1'b0;
                  key_ready <= (state == S_READY);
               end
            end
            S_EXPAND: begin
               key_ready <= 1'b0;
               if (key_load) begin
                  rk[0] <= key_in;
                  i     <= 4'd1;
                  rcon  <= RCON_INIT;
                  busy  <= 1'b1;
               end else begin
                  rk[i] <= next_key;
                  rcon  <= xtime(rcon);
                  if (i == LAST) begin
                     state <= S_READY;
                     busy  <= 1'b0;
                  end else begin
                     i <= i + 4'd1;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               key_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 vectors, latency, restart, reset and reload cases.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_load;
   logic [127:0] key_in;
   logic [3:0]   round_index;
   logic [127:0] round_key;
   logic         key_ready;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   aes_key_expand dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_load    (key_load),
      .key_in      (key_in),
      .round_index (round_index),
      .round_key   (round_key),
      .key_ready   (key_ready),
      .busy        (busy)
   );

   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
      logic [127:0] exp;
   } vec_t;

   localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_ZERO = 128'h0;
   localparam logic [127:0] Z_RK1    = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_RK10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic [127:0] gold [0:10];
   vec_t         vecs [0:17];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Leaves the caller just after the edge that sampled key_load.
   task automatic pulse_load(input logic [127:0] k);
      @(negedge clk);
      key_in   = k;
      key_load = 1'b1;
      @(posedge clk);
      #1;
      key_load = 1'b0;
   endtask

   task automatic wait_ready(output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = busy ? 1 : 0;
      while (!key_ready && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      int           cyc, bcnt;
      logic [127:0] cur_key;
      logic         loaded;

      gold[0]  = KEY_A1;
      gold[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      gold[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      gold[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      gold[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      gold[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      gold[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      gold[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      gold[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      gold[9]  = 128'hac7766f319fadc2128d12941575c006e;
      gold[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      for (int n = 0; n < 16; n++) begin
         vecs[n].key = KEY_A1;
         vecs[n].idx = 4'(n);
         vecs[n].exp = (n <= 10) ? gold[n] : 128'h0;
      end
      vecs[16] = '{KEY_ZERO, 4'd1,  Z_RK1};
      vecs[17] = '{KEY_ZERO, 4'd10, Z_RK10};

      rst_n       = 1'b0;
      key_load    = 1'b0;
      key_in      = '0;
      round_index = 4'd0;
      #1;
      check("reset_key_ready", 128'(key_ready), 128'd0);
      check("reset_busy",      128'(busy),      128'd0);
      check("reset_round_key", round_key,       128'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      loaded  = 1'b0;
      cur_key = '0;
      for (int n = 0; n < 18; n++) begin
         if (!loaded || vecs[n].key !== cur_key) begin
            pulse_load(vecs[n].key);
            wait_ready(cyc, bcnt);
            check("load_latency",     128'(cyc),  128'd11);
            check("load_busy_cycles", 128'(bcnt), 128'd10);
            cur_key = vecs[n].key;
            loaded  = 1'b1;
         end
         round_index = vecs[n].idx;
         #1;
         check($sformatf("vec%0d_rk%0d", n, vecs[n].idx), round_key, vecs[n].exp);
      end

      // Restart: second key_load four cycles into an expansion.
      pulse_load(KEY_ZERO);
      repeat (3) @(posedge clk);
      pulse_load(KEY_A1);
      wait_ready(cyc, bcnt);
      check("restart_latency", 128'(cyc), 128'd11);
      round_index = 4'd1;  #1; check("restart_rk1",  round_key, gold[1]);
      round_index = 4'd5;  #1; check("restart_rk5",  round_key, gold[5]);
      round_index = 4'd10; #1; check("restart_rk10", round_key, gold[10]);

      // Reload from READY.
      pulse_load(KEY_ZERO);
      check("reload_ready_drop", 128'(key_ready), 128'd0);
      check("reload_busy_rise",  128'(busy),      128'd1);
      wait_ready(cyc, bcnt);
      check("reload_latency", 128'(cyc), 128'd11);
      round_index = 4'd10; #1; check("reload_rk10", round_key, Z_RK10);

      // Asynchronous reset during expansion.
      pulse_load(KEY_A1);
      repeat (4) @(posedge clk);
      #2;
      round_index = 4'd1;
      rst_n = 1'b0;
      #1;
      check("midrst_key_ready", 128'(key_ready), 128'd0);
      check("midrst_busy",      128'(busy),      128'd0);
      check("midrst_round_key", round_key,       128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(cyc, bcnt);
      check("midrst_no_ready", 128'(key_ready), 128'd0);
      check("midrst_no_busy",  128'(bcnt),      128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
